// File: rtl/data_ram_arbiter_if.sv
// rtl/data_ram_arbiter_if.sv - CPU, aux and RAM-side signal bundle for data_ram_arbiter
interface data_ram_arbiter_if;
    logic        cpu_en_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_wdata_i;
    logic [31:0] cpu_rdata_o;
    logic        cpu_stall_o;
    logic        aux_req_i;
    logic [31:0] aux_addr_i;
    logic [31:0] aux_rdata_o;
    logic        aux_valid_o;
    logic        ram_enable_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    modport slave (
        input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, aux_req_i, aux_addr_i, ram_rdata_i,
        output cpu_rdata_o, cpu_stall_o, aux_rdata_o, aux_valid_o,
               ram_enable_o, ram_we_o, ram_addr_o, ram_wdata_o
    );

    modport master (
        output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, aux_req_i, aux_addr_i, ram_rdata_i,
        input  cpu_rdata_o, cpu_stall_o, aux_rdata_o, aux_valid_o,
               ram_enable_o, ram_we_o, ram_addr_o, ram_wdata_o
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - CPU-priority arbiter for the data RAM port; ARB_STARVE_GUARD_EN adds forced aux grants
module data_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               clk,
    input  logic               reset,
    data_ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t      state;
    logic        aux_pending;
    logic        forced;
    logic        aux_grant;
    logic        aux_valid_q;
    logic [31:0] aux_rdata_q;

    // A request raised during RESP or reset is not eligible this cycle.
    assign aux_pending = !reset && bus.aux_req_i && (state != RESP);

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign forced = aux_pending && bus.cpu_en_i && (starve_cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || !aux_pending || aux_grant) begin
            starve_cnt <= 8'd0;
        end else if (starve_cnt < LIMIT) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    logic unused_limit;
    assign unused_limit = ^LIMIT;
    assign forced       = 1'b0;
`endif

    assign aux_grant = aux_pending && (!bus.cpu_en_i || forced);

    always_comb begin
        bus.ram_enable_o = 1'b0;
        bus.ram_we_o     = 1'b0;
        bus.ram_addr_o   = 32'd0;
        bus.ram_wdata_o  = 32'd0;
        bus.cpu_rdata_o  = bus.ram_rdata_i;
        bus.cpu_stall_o  = 1'b0;
        if (aux_grant) begin
            bus.ram_enable_o = 1'b1;
            bus.ram_addr_o   = bus.aux_addr_i;
            bus.cpu_rdata_o  = 32'd0;
            bus.cpu_stall_o  = forced;
        end else if (bus.cpu_en_i) begin
            bus.ram_enable_o = 1'b1;
            bus.ram_we_o     = bus.cpu_we_i;
            bus.ram_addr_o   = bus.cpu_addr_i;
            bus.ram_wdata_o  = bus.cpu_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            aux_valid_q <= 1'b0;
            aux_rdata_q <= 32'd0;
        end else begin
            aux_valid_q <= 1'b0;
            case (state)
                IDLE, WAIT: begin
                    if (aux_grant) begin
                        state       <= RESP;
                        aux_valid_q <= 1'b1;
                        aux_rdata_q <= bus.ram_rdata_i;
                    end else if (bus.aux_req_i) begin
                        state <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.aux_valid_o = aux_valid_q;
    assign bus.aux_rdata_o = aux_rdata_q;
endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-master arbiter sharing the single data RAM / MMIO port between the pipeline MEM stage (CPU) and an auxiliary read-only master (display fetcher, debug reader). The CPU has priority. A starvation guard forces one auxiliary access after a bounded number of denied cycles and stalls the CPU for that cycle. The block sits between the MEM stage and `data_ram`, and drives its `ram_enable`, `is_write_i`, `address` and `data_i` inputs.

## Interface
- `STARVE_LIMIT`, 8: consecutive denied aux-request cycles before aux is forced; legal range 1..255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_en_i`  in  1  CPU memory access this cycle.
- `cpu_we_i`  in  1  CPU write (valid with `cpu_en_i`).
- `cpu_addr_i`  in  32  CPU byte address.
- `cpu_wdata_i`  in  32  CPU write data.
- `cpu_rdata_o`  out  32  CPU read data, combinational.
- `cpu_stall_o`  out  1  CPU access not performed this cycle; MEM stage must hold.
- `aux_req_i`  in  1  aux read request; level, held with stable address until `aux_valid_o`.
- `aux_addr_i`  in  32  aux byte address; MMIO range permitted.
- `aux_rdata_o`  out  32  registered aux read data.
- `aux_valid_o`  out  1  one-cycle pulse; `aux_rdata_o` valid.
- `ram_enable_o`, `ram_we_o`  out  1 each  to RAM enable / write.
- `ram_addr_o`, `ram_wdata_o`  out  32 each  to RAM address / write data.
- `ram_rdata_i`  in  32  RAM combinational read data.

## Operation
- States: IDLE (no aux pending), WAIT (aux requested, denied ≥1 cycle), RESP (aux data returning).
- Owner per cycle:
  - In IDLE/WAIT with `aux_req_i=1`: aux owns if `cpu_en_i=0` or `starve_cnt==STARVE_LIMIT` (forced); otherwise CPU owns.
  - In RESP: CPU always owns.
- CPU owns: `ram_*` = CPU signals passthrough; `cpu_rdata_o=ram_rdata_i`; `cpu_stall_o=0`.
- Aux owns: `ram_enable_o=1`, `ram_we_o=0`, `ram_addr_o=aux_addr_i`, `ram_wdata_o=0`. At the edge, `aux_rdata_o<=ram_rdata_i` and state goes to RESP.
- Forced aux cycle with `cpu_en_i=1`: `cpu_stall_o=1`, `cpu_rdata_o=0`, and the CPU write is suppressed.
- Neither master active: `ram_enable_o=0` and `ram_we_o=0`; address and data are don't-care, driven 0.
- `starve_cnt` (8 bit):
  - Increments each cycle aux is requesting and denied; saturates at `STARVE_LIMIT`.
  - Cleared on aux grant, on `aux_req_i` dropping, and on reset.
- Transitions:
  - IDLE → WAIT on a denied request.
  - IDLE/WAIT → RESP on grant.
  - WAIT → IDLE if `aux_req_i` drops; the request is abandoned and no pulse is issued.
  - RESP → IDLE unconditionally.
- `aux_valid_o=1` only in RESP. `aux_req_i` seen high in RESP is ignored; it is re-evaluated in IDLE the next cycle as a new request.

## Timing
- Reset values: state IDLE, `starve_cnt=0`, `aux_valid_o=0`, `aux_rdata_o=0`.
- Combinational outputs during reset follow CPU passthrough, with `cpu_stall_o=0`.
- Reset mid-transaction (WAIT or RESP) discards the request; no `aux_valid_o` pulse follows.
- Aux latency:
  - Grant in request cycle N if CPU idle; `aux_valid_o` in N+1.
  - Worst case: grant at N+`STARVE_LIMIT`, valid at N+`STARVE_LIMIT`+1.
- Minimum aux request spacing is 2 cycles (grant + RESP).
- `cpu_stall_o` is combinational and never asserted for two consecutive cycles.
- Between forced grants the CPU gets at least `STARVE_LIMIT`+1 unstalled cycles.
- The RAM write commits at the grant edge for CPU writes only.

## Configuration
- `ARB_STARVE_GUARD_EN` defined: starvation counter and forced aux grant as above.
- Undefined:
  - Strict CPU priority; `starve_cnt` is absent and `cpu_stall_o` is tied 0.
  - Aux is granted only in cycles with `cpu_en_i=0`, so aux latency is unbounded.

## Test plan
- Reset held 2 cycles with `aux_req_i=1`: `aux_valid_o=0` and `aux_rdata_o=0` throughout. After release with `cpu_en_i=0`, grant occurs in the first cycle and `aux_valid_o` pulses the next cycle.
- CPU idle, aux reads 0x00000000 (RAM holds 0x7593): `aux_rdata_o=0x00007593` with `aux_valid_o` one cycle after the request; `cpu_stall_o=0`.
- Guard enabled, `STARVE_LIMIT=8`, CPU reading every cycle, aux requests 0x40000014:
  - 8 denied cycles, then one cycle with `cpu_stall_o=1`, `ram_addr_o=0x40000014`, `ram_we_o=0`.
  - `aux_valid_o` the next cycle; the CPU is unstalled in that RESP cycle.
- Forced cycle coinciding with a CPU write of 0x1234 to 0x4000000C: no write that cycle. The write lands one cycle later when the MEM stage holds, and the LED register reads 0x34 afterward.
- Aux drops `aux_req_i` after 3 denied cycles: returns to IDLE, `starve_cnt=0`, no `aux_valid_o` pulse. A new request then restarts the 8-cycle count.
- Guard disabled, CPU busy 50 cycles: `cpu_stall_o` stays 0 and aux is never granted. First idle CPU cycle → grant, then `aux_valid_o` the following cycle.
